// File: rtl/dequant_state_unpack_if.sv
// Handshake bundle between the Ct state buffer read port and the MAC accumulator input.
// The master side drives words in and accepts elements out; the slave side is the unpacker.
interface dequant_state_unpack_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;

   modport master (
      output in_valid,
      output in_word,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_last
   );

   modport slave (
      input  in_valid,
      input  in_word,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_last
   );
endinterface

// File: rtl/dequant_state_unpack.sv
// Unpacks 32-bit words of quantized Ct bytes (byte0 first) into signed 32-bit dequantized
// elements, one per handshake, flagging the last element of each VEC_LEN-element vector.
module dequant_state_unpack #(
   parameter logic [7:0]  ZERO_STATE = 8'd128,
   parameter logic [9:0]  SCALE_W    = 10'd128,
   parameter logic [15:0] VEC_LEN    = 16'd64
) (
   input logic                    clk,
   input logic                    resetn,
   input logic                    clear,
   dequant_state_unpack_if.slave  bus
);

   localparam logic [0:0]  IDLE     = 1'b0;
   localparam logic [0:0]  EMIT     = 1'b1;
   localparam logic [15:0] LAST_IDX = VEC_LEN - 16'd1;

   function automatic logic [31:0] deq(input logic [7:0] q);
      logic signed [8:0]  diff;
      logic signed [31:0] wide;
      logic signed [31:0] scale;
      diff  = $signed({1'b0, q}) - $signed({1'b0, ZERO_STATE});
      wide  = {{23{diff[8]}}, diff};
      scale = $signed({22'd0, SCALE_W});
      return wide * scale;
   endfunction

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
      logic [7:0] b;
      unique case (i)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

   logic [0:0]  state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] data_q, data_d;
   logic        last_q, last_d;

   logic word_done;
   logic xfer;
   logic accept;
   logic in_ready;

   // The last element of a vector also finishes its word; leftover bytes are dropped.
   assign word_done = (idx_q == 2'd3) || last_q;
   assign xfer      = (state_q == EMIT) && bus.out_ready && !clear;

   always_comb begin
      in_ready = 1'b0;
      if (!clear) begin
         if (state_q == IDLE) begin
            in_ready = 1'b1;
         end else begin
            in_ready = word_done && bus.out_ready;
         end
      end
   end

   assign accept        = bus.in_valid && in_ready;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == EMIT);
   assign bus.out_data  = data_q;
   assign bus.out_last  = last_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      data_d  = data_q;
      last_d  = last_q;
      if (clear) begin
         state_d = IDLE;
         idx_d   = 2'd0;
         cnt_d   = 16'd0;
      end else begin
         if (xfer) begin
            cnt_d = last_q ? 16'd0 : cnt_q + 16'd1;
         end
         // cnt_d is the index of whichever element gets loaded this cycle.
         if (accept) begin
            state_d = EMIT;
            buf_d   = bus.in_word;
            idx_d   = 2'd0;
            data_d  = deq(bus.in_word[7:0]);
            last_d  = (cnt_d == LAST_IDX);
         end else if (xfer) begin
            if (word_done) begin
               state_d = IDLE;
            end else begin
               idx_d  = idx_q + 2'd1;
               data_d = deq(byte_sel(buf_q, idx_q + 2'd1));
               last_d = (cnt_d == LAST_IDX);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= 16'd0;
         buf_q   <= 32'd0;
         data_q  <= 32'd0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_dequant_state_unpack.sv
// Directed bench for dequant_state_unpack: a VEC_LEN=64 instance and a VEC_LEN=6 instance
// driven on the falling edge and checked 1 time unit later.
module tb_dequant_state_unpack;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic clear_a = 1'b0;
   logic clear_b = 1'b0;

   always #5 clk = ~clk;

   dequant_state_unpack_if a ();
   dequant_state_unpack_if b ();

   dequant_state_unpack u_dut64 (
      .clk    (clk),
      .resetn (resetn),
      .clear  (clear_a),
      .bus    (a)
   );

   dequant_state_unpack #(
      .VEC_LEN (16'd6)
   ) u_dut6 (
      .clk    (clk),
      .resetn (resetn),
      .clear  (clear_b),
      .bus    (b)
   );

   int n_cmp = 0;
   int n_err = 0;

   int          exp1[4]    = '{0, 128, 16256, -16384};
   logic [31:0] words3[3]  = '{32'h00FF_8180, 32'h7F82_0180, 32'hC040_FE02};
   int          exp3[12]   = '{0, 128, 16256, -16384, 0, -16256, 256, -128,
                               -16128, 16128, -8192, 8192};
   logic [31:0] words4[3]  = '{32'h0403_0201, 32'h0807_0605, 32'h0000_0080};
   int          exp4[7]    = '{-16256, -16128, -16000, -15872, -15744, -15616, 0};
   logic        last4[7]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int k;
      int w;
      int n;
      int first;
      int lastc;

      a.in_valid = 1'b0; a.in_word = 32'd0; a.out_ready = 1'b0;
      b.in_valid = 1'b0; b.in_word = 32'd0; b.out_ready = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", a.out_valid, 1'b0);
      chk("rst_data", a.out_data, 32'd0);
      chk("rst_last", a.out_last, 1'b0);
      chk("rst_valid6", b.out_valid, 1'b0);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("rst_in_ready", a.in_ready, 1'b1);

      // Single word, out_ready held high
      @(negedge clk);
      a.in_valid = 1'b1; a.in_word = 32'h00FF_8180; a.out_ready = 1'b1;
      #1;
      chk("t1_idle_ready", a.in_ready, 1'b1);
      chk("t1_idle_valid", a.out_valid, 1'b0);
      @(negedge clk);
      a.in_valid = 1'b0;
      #1;
      chk("t1_valid", a.out_valid, 1'b1);
      chk("t1_b0", a.out_data, 32'd0);
      chk("t1_ready_b0", a.in_ready, 1'b0);
      @(negedge clk);
      #1;
      chk("t1_b1", a.out_data, 32'd128);
      chk("t1_ready_b1", a.in_ready, 1'b0);
      @(negedge clk);
      #1;
      chk("t1_b2", a.out_data, 32'd16256);
      @(negedge clk);
      #1;
      chk("t1_b3", a.out_data, -32'sd16384);
      chk("t1_ready_b3", a.in_ready, 1'b1);
      chk("t1_last", a.out_last, 1'b0);
      @(negedge clk);
      #1;
      chk("t1_done", a.out_valid, 1'b0);

      // Backpressure: out_ready 1,0,0,1,0,0,...
      @(negedge clk);
      a.in_valid = 1'b1; a.in_word = 32'h00FF_8180; a.out_ready = 1'b0;
      @(negedge clk);
      a.in_valid = 1'b0;
      k = 0;
      for (int c = 0; c < 20 && k < 4; c++) begin
         if (c > 0) @(negedge clk);
         a.out_ready = (c % 3 == 0);
         #1;
         chk("t2_valid", a.out_valid, 1'b1);
         chk("t2_data", a.out_data, exp1[k]);
         if (a.out_ready) k++;
      end
      chk("t2_count", k, 4);
      @(negedge clk);
      a.out_ready = 1'b0;
      #1;
      chk("t2_no_dup", a.out_valid, 1'b0);

      // Back-to-back: three words with in_valid held high
      w = 0; n = 0; first = -1; lastc = -1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         a.out_ready = 1'b1;
         a.in_valid  = (w < 3);
         if (w < 3) a.in_word = words3[w];
         #1;
         if (a.out_valid) begin
            if (n < 12) chk("t3_data", a.out_data, exp3[n]);
            if (n < 11) chk("t3_in_ready", a.in_ready, (n == 3) || (n == 7));
            if (first < 0) first = c;
            lastc = c;
            n++;
         end
         if (a.in_valid && a.in_ready) w++;
      end
      a.in_valid = 1'b0;
      chk("t3_count", n, 12);
      chk("t3_no_bubble", lastc - first, 11);

      // clear at idx=2 with out_ready=0 on the VEC_LEN=6 instance
      @(negedge clk);
      b.in_valid = 1'b1; b.in_word = 32'h0403_0201; b.out_ready = 1'b1;
      @(negedge clk);
      b.in_valid = 1'b0;
      #1;
      chk("clr_e0", b.out_data, -32'sd16256);
      @(negedge clk);
      #1;
      chk("clr_e1", b.out_data, -32'sd16128);
      @(negedge clk);
      b.out_ready = 1'b0; clear_b = 1'b1;
      #1;
      chk("clr_e2", b.out_data, -32'sd16000);
      chk("clr_in_ready", b.in_ready, 1'b0);
      @(negedge clk);
      clear_b = 1'b0;
      #1;
      chk("clr_valid", b.out_valid, 1'b0);
      chk("clr_idle_ready", b.in_ready, 1'b1);

      // Partial last word: vector of 6 spans word0 + half of word1; word2 starts a new vector
      w = 0; n = 0;
      for (int c = 0; c < 30 && n < 7; c++) begin
         @(negedge clk);
         b.out_ready = 1'b1;
         b.in_valid  = (w < 3);
         if (w < 3) b.in_word = words4[w];
         #1;
         if (b.out_valid) begin
            chk("t4_data", b.out_data, exp4[n]);
            chk("t4_last", b.out_last, last4[n]);
            if (n == 5) chk("t4_word_end", b.in_ready, 1'b1);
            n++;
         end
         if (b.in_valid && b.in_ready) w++;
      end
      chk("t4_count", n, 7);
      @(negedge clk);
      b.in_valid = 1'b0; clear_b = 1'b1;
      @(negedge clk);
      clear_b = 1'b0;

      // Asynchronous reset between clock edges, mid-word
      @(negedge clk);
      a.in_valid = 1'b1; a.in_word = 32'h7F82_0180; a.out_ready = 1'b1;
      @(negedge clk);
      a.in_valid = 1'b0;
      #1;
      chk("ar_b0", a.out_data, 32'd0);
      @(negedge clk);
      #1;
      chk("ar_b1", a.out_data, -32'sd16256);
      #1;
      resetn = 1'b0;
      #1;
      chk("ar_valid", a.out_valid, 1'b0);
      chk("ar_data", a.out_data, 32'd0);
      chk("ar_last", a.out_last, 1'b0);
      @(negedge clk);
      resetn = 1'b1; a.out_ready = 1'b0;
      #1;
      chk("ar_in_ready", a.in_ready, 1'b1);
      chk("ar_idle", a.out_valid, 1'b0);
      a.in_valid = 1'b1; a.in_word = 32'hC040_FE02;
      @(negedge clk);
      a.in_valid = 1'b0; a.out_ready = 1'b1;
      #1;
      chk("ar_fresh_valid", a.out_valid, 1'b1);
      chk("ar_fresh_b0", a.out_data, -32'sd16128);
      chk("ar_fresh_last", a.out_last, 1'b0);
      @(negedge clk);
      #1;
      chk("ar_fresh_b1", a.out_data, 32'd16128);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dequant_state_unpack.md
Name: dequant_state_unpack

Overview:
- Inverse of the Ct quantization path: turns packed 8-bit quantized cell-state (Ct) bytes back into signed 32-bit accumulator-domain values for the next inner-product pass.
- Takes 32-bit words from the state buffer (4 bytes per word) and emits one dequantized element per handshake.
- Marks the last element of each VEC_LEN-element state vector.
- Sits between the Ct state SRAM read port and the MAC accumulator input.

Parameters:
- ZERO_STATE, 8'd128, zero point of quantized Ct.
- SCALE_W, 10'd128, multiplier applied after zero-point removal; matches the divisor used on the quantization side.
- VEC_LEN, 16'd64, elements per state vector, 1..65535; need not be a multiple of 4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous; drop the buffered word and restart the element count.
- in_valid  in  1  in_word valid.
- in_ready  out  1  block accepts in_word this cycle.
- in_word  in  32  packed Ct bytes; byte0 = [7:0] is emitted first, byte3 = [31:24] last.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  32  signed dequantized value.
- out_last  out  1  out_data is element VEC_LEN-1 of the vector.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, idx=0, elem_cnt=0, word buffer=0, out_valid=0, out_data=0, out_last=0. in_ready is 1 once reset is released.
- Arithmetic: deq(q) = ($signed({1'b0,q}) - $signed({1'b0,ZERO_STATE})) * $signed({1'b0,SCALE_W}), sign-extended to 32 bits, no saturation. With defaults the range is -16384..16256.
- Input handshake: a word is accepted when in_valid && in_ready.
- Output handshake: an element transfers when out_valid && out_ready.
- out_data and out_last are registered and must hold stable while out_valid=1 && out_ready=0.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On accept: buffer<=in_word, idx<=0, out_data<=deq(in_word[7:0]), go to EMIT.
  - EMIT: out_valid=1. On transfer with idx<3 and the element not last: idx++, out_data<=deq(buffer byte idx+1).
  - Word-end: if the transfer is at idx==3 or on the last element, the rest of the word is finished.
    - in_ready = out_ready in that cycle (combinational), so back-to-back words need no bubble.
    - If in_valid=1 in that cycle, load the new word as in IDLE and stay in EMIT.
    - Otherwise go to IDLE.
  - In EMIT, in_ready=0 except in the word-end transfer cycle.
- Latency: word accepted at edge N; byte0 appears with out_valid=1 in the cycle after edge N. Steady-state throughput is 1 element/cycle.
- Element count:
  - elem_cnt increments on every output transfer.
  - out_last = (elem_cnt == VEC_LEN-1), registered alongside out_data.
  - On the out_last transfer, elem_cnt wraps to 0.
  - Any unused bytes of the current word are discarded (the word is treated as finished).
  - The next vector always starts at byte0 of a fresh word.
- VEC_LEN=1: every element is last; only byte0 of each word is used.
- clear=1 (synchronous; overrides in_valid and out_ready that cycle):
  - state<=IDLE, idx<=0, elem_cnt<=0, out_valid<=0.
  - No transfer occurs in that cycle: in_ready=0 while clear=1.
- Reset mid-operation: everything returns to reset values immediately; the partially emitted word is lost.
- in_word changing while in_ready=0 has no effect.

Test Plan:
- Single word: in_word=32'h00FF_8180, out_ready=1. Required: out_data = 128, -16384? No — emitted in byte order byte0..byte3 = 0x80, 0x81, 0xFF, 0x00, giving 0, 128, 16256, -16384 on 4 consecutive cycles. out_valid rises 1 cycle after accept. in_ready=1 on the 4th transfer.
- Backpressure: same word, out_ready toggling 1,0,0,1,...
  - out_data must hold during stalls.
  - Exactly 4 transfers in byte order; no duplicates or drops.
- Back-to-back: in_valid held high with 3 words, out_ready=1.
  - Exactly 12 consecutive out_valid cycles with no bubble.
  - in_ready pulses only on cycles 4 and 8 of the stream.
- Partial last word: VEC_LEN=6, two words 32'h0403_0201 and 32'h0807_0605.
  - out_last on the 6th element, 0x06 → -15616.
  - Bytes 0x07 and 0x08 are discarded.
  - The next word starts a new vector with elem_cnt=0.
- clear in EMIT at idx=2 with out_ready=0:
  - Next cycle out_valid=0, state=IDLE.
  - The next word's byte0 is emitted with elem_cnt=0, so out_last is asserted after VEC_LEN further elements.
- Asynchronous reset asserted mid-word, between clock edges:
  - out_valid, out_data and out_last go to 0 immediately.
  - After release, in_ready=1 and a fresh word is emitted from byte0.
